// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel readout block and the pixel sequencer.
// Contents:
//   C_BITS_DEF / N_PIX_DEF : default ramp code width and pixel count
//   state_t                : readout phase state encoding
//   sat_code()             : saturation code = min(c_convert, 2^c_bits - 1)
package pixel_pkg;

    localparam int C_BITS_DEF = 8;
    localparam int N_PIX_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ
    } state_t;

    // Largest code a conversion can report: either the ramp runs out of
    // window length or it runs out of bits, whichever comes first.
    function automatic int sat_code(input int c_convert, input int c_bits);
        int full;
        full = (1 << c_bits) - 1;
        return (c_convert < full) ? c_convert : full;
    endfunction

endpackage

// File: rtl/pixel_readout_if.sv
// Pixel word stream from the readout block to the downstream consumer.
// Signals:
//   data    : pixel code being delivered
//   pix_idx : index of the pixel on data
//   valid   : data/pix_idx are valid (held until accepted)
//   ready   : consumer accepts the word when valid & ready
// Modports: master (readout side), slave (consumer side).
interface pixel_readout_if #(
    parameter int c_bits = pixel_pkg::C_BITS_DEF,
    parameter int n_pix  = pixel_pkg::N_PIX_DEF
);
    localparam int idx_w = (n_pix > 1) ? $clog2(n_pix) : 1;

    logic [c_bits-1:0] data;
    logic [idx_w-1:0]  pix_idx;
    logic              valid;
    logic              ready;

    modport master (output data, output pix_idx, output valid, input ready);
    modport slave  (input data, input pix_idx, input valid, output ready);
endinterface

// File: rtl/ramp_counter.sv
// Saturating up-counter driving the single-slope DAC ramp.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count up by one per cycle
//   sat        : value at which counting stops
//   count      : current counter value
module ramp_counter #(
    parameter int c_bits = pixel_pkg::C_BITS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [c_bits-1:0] sat,
    output logic [c_bits-1:0] count
);

    // NOTE: state registers are updated with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count < sat)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Column readout for a small pixel array: runs the erase/expose/convert/read
// phase FSM, digitises each pixel with a shared single-slope ramp and
// streams the stored codes out one word per read request.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   erase      : strobe, clear stored codes (highest priority)
//   expose     : level, integration in progress
//   convert    : level, conversion window
//   read       : one-hot pixel select (valid only in READ)
//   cmp        : per-pixel comparator, 1 when ramp >= pixel level
//   ramp       : DAC ramp code (0 outside CONVERT)
//   err        : sticky protocol error
//   stream     : pixel word stream (data, pix_idx, valid, ready)
module pixel_readout
    import pixel_pkg::*;
#(
    parameter int c_bits    = C_BITS_DEF,
    parameter int n_pix     = N_PIX_DEF,
    parameter int c_convert = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              convert,
    input  logic [n_pix-1:0]  read,
    input  logic [n_pix-1:0]  cmp,
    output logic [c_bits-1:0] ramp,
    output logic              err,
    pixel_readout_if.master   stream
);

    localparam int idx_w = (n_pix > 1) ? $clog2(n_pix) : 1;
    localparam logic [c_bits-1:0] sat = c_bits'(sat_code(c_convert, c_bits));

    state_t             state;
    logic [c_bits-1:0]  code [n_pix];
    logic [n_pix-1:0]   done;
    logic [idx_w-1:0]   last_idx;
    logic               last_vld;   // last_idx holds a delivered pixel
    logic [c_bits-1:0]  count;

    logic               in_convert;
    logic               read_onehot;
    logic               read_bad;
    logic [idx_w-1:0]   read_k;
    logic               read_repeat;

    // The counter is held at 0 in every other phase, so the first CONVERT
    // cycle always starts from ramp 0.
    assign in_convert = (state == ST_CONVERT);

    ramp_counter #(.c_bits(c_bits)) u_ramp (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_convert),
        .en    (in_convert),
        .sat   (sat),
        .count (count)
    );

    // Gate so the counter's last value never leaks into the READ phase.
    assign ramp = in_convert ? count : '0;

    assign read_onehot = (read != '0) && ((read & (read - 1'b1)) == '0);
    assign read_bad    = (read != '0) && !read_onehot;
    assign read_repeat = last_vld && (read_k == last_idx);

    // NOTE: every variable written here gets a default first; otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        read_k = '0;
        for (int i = 0; i < n_pix; i++) begin
            if (read[i]) read_k = idx_w'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            err            <= 1'b0;
            done           <= '0;
            last_idx       <= '0;
            last_vld       <= 1'b0;
            stream.data    <= '0;
            stream.pix_idx <= '0;
            stream.valid   <= 1'b0;
            // NOTE: the code store is a handful of flops, not a RAM, and
            // reset must discard partial conversions, so it is reset here.
            for (int i = 0; i < n_pix; i++) code[i] <= '0;
        end else begin
            if (read_bad || ((read != '0) && (state != ST_READ))) err <= 1'b1;

            if (stream.valid && stream.ready) stream.valid <= 1'b0;

            if (erase) begin
                // Clear on entry so CLEAR is already a clean frame; the
                // delivered-index memory is per frame, so it goes too.
                state        <= ST_CLEAR;
                done         <= '0;
                last_vld     <= 1'b0;
                stream.valid <= 1'b0;
                for (int i = 0; i < n_pix; i++) code[i] <= '0;
            end else begin
                case (state)
                    ST_CLEAR: state <= ST_IDLE;

                    ST_IDLE: begin
                        if (convert)     state <= ST_CONVERT;
                        else if (expose) state <= ST_EXPOSE;
                    end

                    ST_EXPOSE: begin
                        if (convert)      state <= ST_CONVERT;
                        else if (!expose) state <= ST_IDLE;
                    end

                    ST_CONVERT: begin
                        // First comparator hit latches the ramp; pixels that
                        // never fired by the end of the window saturate.
                        for (int i = 0; i < n_pix; i++) begin
                            if (!done[i]) begin
                                if (cmp[i]) begin
                                    code[i] <= count;
                                    done[i] <= 1'b1;
                                end else if (!convert) begin
                                    code[i] <= sat;
                                    done[i] <= 1'b1;
                                end
                            end
                        end
                        if (!convert) state <= ST_READ;
                    end

                    ST_READ: begin
                        if (convert && stream.valid) begin
                            err          <= 1'b1;
                            stream.valid <= 1'b0;
                            state        <= ST_CONVERT;
                        end else if (read_onehot && !stream.valid && !read_repeat) begin
                            stream.data    <= code[read_k];
                            stream.pix_idx <= read_k;
                            stream.valid   <= 1'b1;
                            last_idx       <= read_k;
                            last_vld       <= 1'b1;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: reset behaviour, a full frame with four
// pixel levels, back-pressure, protocol errors, comparator glitches and
// ramp saturation.
module tb_pixel_readout;
    import pixel_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       erase;
    logic       expose;
    logic       convert;
    logic [3:0] read;
    logic [3:0] cmp;
    logic [7:0] ramp;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;

    // Pixel model: comparator fires once the ramp reaches the pixel level.
    int         lvl [4] = '{17, 0, 200, 0};
    logic [3:0] cmp_en;
    logic       toggle_mode;

    pixel_readout_if #(.c_bits(8), .n_pix(4)) bus ();

    pixel_readout #(.c_bits(8), .n_pix(4), .c_convert(255)) dut (
        .clk     (clk),
        .reset   (reset),
        .erase   (erase),
        .expose  (expose),
        .convert (convert),
        .read    (read),
        .cmp     (cmp),
        .ramp    (ramp),
        .err     (err),
        .stream  (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) cmp[i] = cmp_en[i] && (int'(ramp) >= lvl[i]);
        if (toggle_mode) cmp[0] = (ramp == 8'd10) || (ramp >= 8'd40);
    end

    always @(posedge clk) begin
        if (bus.valid && bus.ready) n_xfer++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_erase();
        erase = 1'b1;
        tick();
        erase = 1'b0;
        tick();
    endtask

    // Convert window of n cycles, then drop convert to enter READ.
    task automatic run_convert(input int n);
        int exp_top;
        exp_top = (n - 1 > 255) ? 255 : n - 1;
        convert = 1'b1;
        repeat (n) tick();
        check($sformatf("ramp_top_n%0d", n), 32'(ramp), exp_top);
        convert = 1'b0;
        tick();
        check("ramp_zero_in_read", 32'(ramp), 0);
    endtask

    task automatic read_pixel(input int k, input int exp);
        int          vcnt;
        logic [31:0] d;
        logic [31:0] ix;
        vcnt = 0;
        d    = 32'hffff_ffff;
        ix   = 32'hffff_ffff;
        bus.ready = 1'b1;
        read = 4'(1 << k);
        repeat (4) begin
            tick();
            if (bus.valid) begin
                vcnt++;
                d  = 32'(bus.data);
                ix = 32'(bus.pix_idx);
            end
        end
        read = '0;
        check($sformatf("data_p%0d", k), d, exp);
        check($sformatf("idx_p%0d", k), ix, k);
        check($sformatf("valid_cycles_p%0d", k), vcnt, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ramp"},  32'(ramp), 0);
        check({tag, "_data"},  32'(bus.data), 0);
        check({tag, "_idx"},   32'(bus.pix_idx), 0);
        check({tag, "_valid"}, 32'(bus.valid), 0);
        check({tag, "_err"},   32'(err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer0;
        logic stable;

        reset = 1'b0; erase = 1'b0; expose = 1'b0; convert = 1'b0;
        read = '0; bus.ready = 1'b0; cmp_en = 4'b0111; toggle_mode = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_zero_outputs("reset");
        reset = 1'b1;
        tick();

        // read outside READ is a protocol error
        read = 4'b0001;
        tick();
        read = '0;
        check("read_outside_err", 32'(err), 1);
        check("read_outside_valid", 32'(bus.valid), 0);
        #2 reset = 1'b0;
        #1 check("reset_clears_err", 32'(err), 0);
        #2 reset = 1'b1;
        tick();

        // Full frame: expose, convert 255 cycles, read every pixel.
        do_erase();
        expose = 1'b1;
        repeat (3) tick();
        run_convert(255);
        expose = 1'b0;
        read_pixel(0, 17);
        read_pixel(1, 0);
        read_pixel(2, 200);
        read_pixel(3, 255);

        // Back-pressure: word for pixel 2 held for 5 cycles.
        xfer0 = n_xfer;
        bus.ready = 1'b0;
        read = 4'b0100;
        tick();
        check("bp_valid", 32'(bus.valid), 1);
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!(bus.valid === 1'b1 && bus.data === 8'd200 && bus.pix_idx === 2'd2))
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 1);
        bus.ready = 1'b1;
        repeat (3) tick();
        read = '0;
        check("bp_one_xfer", n_xfer - xfer0, 1);
        check("bp_valid_dropped", 32'(bus.valid), 0);

        // Convert while a word is pending aborts it.
        bus.ready = 1'b0;
        read = 4'b0001;
        tick();
        check("abort_pre_valid", 32'(bus.valid), 1);
        check("abort_pre_err", 32'(err), 0);
        read = '0;
        convert = 1'b1;
        tick();
        check("abort_err", 32'(err), 1);
        check("abort_valid", 32'(bus.valid), 0);
        check("abort_ramp0", 32'(ramp), 0);
        tick();
        check("abort_ramp1", 32'(ramp), 1);

        // Asynchronous reset mid-conversion, no clock edge needed.
        repeat (5) tick();
        check("pre_reset_ramp", 32'(ramp), 6);
        #2 reset = 1'b0;
        #1 check_zero_outputs("async_reset");
        convert = 1'b0;
        bus.ready = 1'b1;
        @(posedge clk);
        #3 reset = 1'b1;
        tick();

        // Non-one-hot read in READ; err survives erase.
        do_erase();
        run_convert(20);
        check("bad_read_pre_err", 32'(err), 0);
        read = 4'b0011;
        repeat (2) tick();
        read = '0;
        check("bad_read_err", 32'(err), 1);
        check("bad_read_valid", 32'(bus.valid), 0);
        do_erase();
        check("err_sticky_erase", 32'(err), 1);

        // Comparator glitch ignored; long window saturates ramp and code.
        cmp_en = 4'b0000;
        toggle_mode = 1'b1;
        run_convert(300);
        toggle_mode = 1'b0;
        read_pixel(0, 10);
        read_pixel(3, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 Parameter c_bits, default 8, meaning ramp and pixel code width.
REQ-002 Parameter n_pix, default 4, meaning pixel count and width of the read/cmp buses.
REQ-003 Parameter c_convert, default 255, meaning convert-phase length in cycles; saturation code is min(c_convert, 2^c_bits-1).
REQ-004 Port clk, input, 1, single system clock; all logic on the rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port erase, input, 1, phase strobe from the pixel sequencer: clear the stored codes.
REQ-007 Port expose, input, 1, phase level from the pixel sequencer: integration in progress.
REQ-008 Port convert, input, 1, phase level from the pixel sequencer: single-slope conversion window.
REQ-009 Port read, input, n_pix, one-hot pixel select from the pixel sequencer.
REQ-010 Port cmp, input, n_pix, per-pixel comparator output; 1 when ramp >= pixel level.
REQ-011 Port ramp, output, c_bits, DAC ramp code.
REQ-012 Port data, output, c_bits, pixel code being delivered.
REQ-013 Port pix_idx, output, clog2(n_pix), index of the pixel on data.
REQ-014 Port valid, output, 1, data/pix_idx are valid.
REQ-015 Port ready, input, 1, downstream accepts data when valid&ready.
REQ-016 Port err, output, 1, sticky protocol error flag.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, EXPOSE, CONVERT and READ; the priority is erase > convert > expose > read.
REQ-018 Transitions SHALL be: erase=1 -> CLEAR; CLEAR -> IDLE; IDLE+expose -> EXPOSE; EXPOSE+!expose -> IDLE; IDLE/EXPOSE+convert -> CONVERT; CONVERT+!convert -> READ; READ+erase -> CLEAR.
REQ-019 CLEAR SHALL zero all stored codes, clear the per-pixel done flags, set ramp=0 and drop valid; err is not cleared.
REQ-020 In CONVERT, ramp SHALL increment by 1 per cycle from 0 and saturate at the saturation code.
REQ-021 In CONVERT, the first cycle cmp[i]=1 while done[i]=0 SHALL store the current ramp into code[i] and set done[i].
REQ-022 If cmp[i] is already 1 on the first CONVERT cycle, code[i] SHALL be 0.
REQ-023 Later cmp[i] toggles SHALL be ignored.
REQ-024 On leaving CONVERT, every pixel with done[i]=0 SHALL get code[i] = saturation code and done[i] set.
REQ-025 In READ, a cycle with read one-hot (bit k), valid=0 and k different from the last delivered index SHALL load data=code[k], pix_idx=k and assert valid on the next cycle (1-cycle latency).
REQ-026 valid, data and pix_idx SHALL hold stable until the valid&ready cycle; valid drops the cycle after acceptance.
REQ-027 Holding read[k] high over several cycles SHALL produce exactly one word for pixel k.
REQ-028 read=0 SHALL produce no output.
REQ-029 A read value that is neither one-hot nor zero SHALL set err and produce no output.
REQ-030 read asserted outside READ SHALL set err.
REQ-031 convert asserted while valid=1 SHALL set err, abort the pending word (valid->0) and enter CONVERT.
REQ-032 ramp SHALL be 0 outside CONVERT.

Reset
REQ-033 While reset=0 the block SHALL asynchronously force: state=IDLE, ramp=0, data=0, pix_idx=0, valid=0, err=0, all code[i]=0, all done[i]=0, last delivered index = none.
REQ-034 Deassertion of reset SHALL take effect at the next rising clk edge.
REQ-035 Reset mid-CONVERT or mid-handshake SHALL discard all partial results.

Structure
REQ-036 A shared package pixel_pkg SHALL hold the state enum type, the c_bits and n_pix defaults, and the saturation-code function; the pixel sequencer and its bench import the same package.
REQ-037 One sub-module, ramp_counter (saturating up-counter with clear and enable), SHALL be instantiated for the ramp.
REQ-038 The remaining logic (FSM, code store, output register) stays in pixel_readout.

Verification
REQ-039 Scenario 1: reset low mid-run -> all outputs 0 immediately, with no clk edge required.
REQ-040 Scenario 2: erase pulse, then convert for 255 cycles with cmp[0] rising at ramp 17, cmp[1] at 0, cmp[2] at 200, cmp[3] never, then read=0001, 0010, 0100, 1000 with ready=1 -> data 17, 0, 200, 255 with pix_idx 0..3, each valid exactly one cycle.
REQ-041 Scenario 3: read=0100 with ready=0 for 5 cycles, then ready=1 -> data=200 and pix_idx=2 stable throughout, one transfer only.
REQ-042 Scenario 4: read=0011 in READ -> err=1, valid stays 0; a subsequent erase leaves err=1.
REQ-043 Scenario 5: cmp[0] toggling 1,0,1 at ramps 10, 11, 40 -> code[0]=10.
REQ-044 Scenario 6: convert asserted while valid=1 -> err=1, valid->0 next cycle, ramp restarts at 0.
